// File: rtl/hw_pointer_wr.sv
// hw_pointer_wr: reports the hardware's 64-bit ring pointer to a host memory
// slot with a posted Memory Write TLP (2-DW payload) on the 64-bit TRN TX
// interface, each time the pointer differs from the value last written.
// TX ownership is shared with other engines through tx_req/tx_grant.
// Optional feature macro: HW_PTR_MWR64_EN -- when defined, a host address
// above 4 GB is written with a 4-DW MWr64 header; otherwise MWr32 is always
// used and the upper address bits are ignored.
module hw_pointer_wr #(
    parameter logic [7:0] MIN_GAP = 8'd16
) (
    input  logic        trn_clk,
    input  logic        reset,
    input  logic [63:0] hw_pointer,
    input  logic [63:0] host_addr,
    input  logic        host_addr_valid,
    input  logic [15:0] cfg_completer_id,
    input  logic [3:0]  trn_tbuf_av,
    input  logic        trn_tdst_rdy_n,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    output logic        trn_tsrc_dsc_n,
    output logic        tx_req,
    input  logic        tx_grant,
    output logic        tx_driving
);

    typedef enum logic [5:0] {
        S_IDLE = 6'b000001,
        S_WAIT = 6'b000010,
        S_B0   = 6'b000100,
        S_B1   = 6'b001000,
        S_B2   = 6'b010000,
        S_GAP  = 6'b100000
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] snap_q, snap_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] td_q, td_d;
    logic [7:0]  trem_q, trem_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        srdy_q, srdy_d;
    logic        req_q, req_d;
    logic        drv_q, drv_d;

    logic        is64;
    logic        accept;
    logic        unused_bits;

    // Byte-swap one DW so a little-endian host read recovers the value.
    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Header beat: DW0 (fmt/type, length 2) and DW1 (requester ID, tag, BEs).
    function automatic logic [63:0] beat0(input logic wide, input logic [15:0] id);
        logic [7:0] fmt_type;
        fmt_type = wide ? 8'h60 : 8'h40;
        return {fmt_type, 8'h00, 6'b000000, 10'd2, id, 8'h00, 4'hF, 4'hF};
    endfunction

    // Second beat: address (and first payload DW for the 3-DW header form).
    function automatic logic [63:0] beat1(input logic wide, input logic [63:0] a,
                                          input logic [63:0] p);
        if (wide)
            return {a[63:32], a[31:2], 2'b00};
        return {a[31:2], 2'b00, bswap(p[31:0])};
    endfunction

    // Final beat: remaining payload; the 3-DW form leaves the low DW empty.
    function automatic logic [63:0] beat2(input logic wide, input logic [63:0] p);
        if (wide)
            return {bswap(p[31:0]), bswap(p[63:32])};
        return {bswap(p[63:32]), 32'h0};
    endfunction

`ifdef HW_PTR_MWR64_EN
    assign is64        = (addr_q[63:32] != 32'h0);
    assign unused_bits = ^{trn_tbuf_av[3:2], trn_tbuf_av[0]};
`else
    assign is64        = 1'b0;
    assign unused_bits = ^{trn_tbuf_av[3:2], trn_tbuf_av[0], addr_q[63:32]};
`endif

    assign accept = ~srdy_q & ~trn_tdst_rdy_n;

    // Next-state and registered-output logic for the one-hot sequencer.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        addr_d  = addr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        td_d    = td_q;
        trem_d  = trem_q;
        sof_d   = sof_q;
        eof_d   = eof_q;
        srdy_d  = srdy_q;
        req_d   = req_q;
        drv_d   = drv_q;
        case (state_q)
            S_IDLE: begin
                if (host_addr_valid && (hw_pointer != last_q)) begin
                    snap_d  = hw_pointer;
                    addr_d  = host_addr;
                    req_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_grant && trn_tbuf_av[1]) begin
                    drv_d   = 1'b1;
                    td_d    = beat0(is64, cfg_completer_id);
                    trem_d  = 8'h00;
                    sof_d   = 1'b0;
                    eof_d   = 1'b1;
                    srdy_d  = 1'b0;
                    state_d = S_B0;
                end
            end
            S_B0: begin
                if (accept) begin
                    td_d    = beat1(is64, addr_q, snap_q);
                    sof_d   = 1'b1;
                    state_d = S_B1;
                end
            end
            S_B1: begin
                if (accept) begin
                    td_d    = beat2(is64, snap_q);
                    trem_d  = is64 ? 8'h00 : 8'h0F;
                    eof_d   = 1'b0;
                    state_d = S_B2;
                end
            end
            S_B2: begin
                if (accept) begin
                    last_d  = snap_q;
                    td_d    = '0;
                    trem_d  = 8'h00;
                    eof_d   = 1'b1;
                    srdy_d  = 1'b1;
                    req_d   = 1'b0;
                    drv_d   = 1'b0;
                    cnt_d   = 8'd1;
                    state_d = (MIN_GAP == 8'd0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == MIN_GAP)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers; snapshot/address captures carry no reset.
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= '0;
            cnt_q   <= '0;
            td_q    <= '0;
            trem_q  <= 8'h00;
            sof_q   <= 1'b1;
            eof_q   <= 1'b1;
            srdy_q  <= 1'b1;
            req_q   <= 1'b0;
            drv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            td_q    <= td_d;
            trem_q  <= trem_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            srdy_q  <= srdy_d;
            req_q   <= req_d;
            drv_q   <= drv_d;
        end
        snap_q <= snap_d;
        addr_q <= addr_d;
    end

    assign trn_td         = td_q;
    assign trn_trem_n     = trem_q;
    assign trn_tsof_n     = sof_q;
    assign trn_teof_n     = eof_q;
    assign trn_tsrc_rdy_n = srdy_q;
    assign trn_tsrc_dsc_n = 1'b1;
    assign tx_req         = req_q;
    assign tx_driving     = drv_q;

endmodule

// File: tb/tb_hw_pointer_wr.sv
// tb_hw_pointer_wr: scoreboard bench for hw_pointer_wr. A monitor turns each
// write request into an expected TLP built from DW lists, then checks framing,
// beat hold, gap spacing and payload as the DUT transmits.
module tb_hw_pointer_wr;

    localparam int GAP = 4;

    typedef struct packed {
        logic [63:0] b0;
        logic [63:0] b1;
        logic [63:0] b2;
        logic [7:0]  trem;
    } tlp_t;

    logic        trn_clk = 1'b0;
    logic        reset;
    logic [63:0] hw_pointer;
    logic [63:0] host_addr;
    logic        host_addr_valid;
    logic [15:0] cfg_completer_id;
    logic [3:0]  trn_tbuf_av;
    logic        trn_tdst_rdy_n;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
    logic        tx_req, tx_grant, tx_driving;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int ph = 0;

    tlp_t        exp_q[$];
    logic [63:0] ptr_q[$];
    logic [63:0] model_last = '0;
    logic [63:0] got[3];
    logic [63:0] last_b0, last_b1, last_b2;
    logic [7:0]  last_trem;
    int          beat_idx = 0;
    int          tlp_cnt = 0;
    int          eof_edge = 0;
    logic        have_eof = 1'b0;
    logic        held = 1'b0;
    logic [63:0] held_td;
    logic [10:0] held_ctl;
    logic        req_prev = 1'b0, srdy_prev = 1'b1, gc_prev = 1'b0, prev_valid = 1'b0;
    logic [63:0] prev_ptr, prev_addr;

    hw_pointer_wr #(.MIN_GAP(8'(GAP))) dut (
        .trn_clk(trn_clk), .reset(reset), .hw_pointer(hw_pointer),
        .host_addr(host_addr), .host_addr_valid(host_addr_valid),
        .cfg_completer_id(cfg_completer_id), .trn_tbuf_av(trn_tbuf_av),
        .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_td(trn_td), .trn_trem_n(trn_trem_n),
        .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
        .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tsrc_dsc_n(trn_tsrc_dsc_n),
        .tx_req(tx_req), .tx_grant(tx_grant), .tx_driving(tx_driving)
    );

    always #5 trn_clk = ~trn_clk;
    always @(posedge trn_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected TLP: header DWs, address DW(s), then the pointer as host memory
    // bytes (byte 0 first on the wire), packed two DWs per beat.
    function automatic tlp_t model_tlp(input logic [63:0] p, input logic [63:0] a,
                                       input logic [15:0] id);
        logic [31:0] dw[$];
        logic [31:0] w;
        logic        wide;
        tlp_t        t;
`ifdef HW_PTR_MWR64_EN
        wide = (a[63:32] != 32'h0);
`else
        wide = 1'b0;
`endif
        w = '0;
        dw.push_back({1'b0, (wide ? 2'b11 : 2'b10), 5'b00000, 1'b0, 3'b000, 4'b0000,
                      1'b0, 1'b0, 2'b00, 2'b00, 10'd2});
        dw.push_back({id, 8'h00, 4'hF, 4'hF});
        if (wide) dw.push_back(a[63:32]);
        dw.push_back({a[31:2], 2'b00});
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 4; b++) w[31-8*b -: 8] = p[8*(4*d+b) +: 8];
            dw.push_back(w);
        end
        t.trem = (dw.size() % 2 == 1) ? 8'h0F : 8'h00;
        if (dw.size() % 2 == 1) dw.push_back(32'h0);
        t.b0 = {dw[0], dw[1]};
        t.b1 = {dw[2], dw[3]};
        t.b2 = {dw[4], dw[5]};
        return t;
    endfunction

    // Monitor: sample mid-cycle, push expectations on tx_req rise, check beats.
    always @(negedge trn_clk) begin
        tlp_t e;
        if (reset) begin
            exp_q.delete();
            ptr_q.delete();
            beat_idx   = 0;
            held       = 1'b0;
            have_eof   = 1'b0;
            model_last = '0;
        end else begin
            if (tx_req && !req_prev) begin
                chk("req_only_on_change", 64'(prev_ptr != model_last), 64'd1);
                chk("req_only_when_valid", 64'(prev_valid), 64'd1);
                if (have_eof)
                    chk("eof_to_req_spacing", 64'((cyc - eof_edge) >= GAP + 1), 64'd1);
                exp_q.push_back(model_tlp(prev_ptr, prev_addr, cfg_completer_id));
                ptr_q.push_back(prev_ptr);
            end
            if (!trn_tsrc_rdy_n && srdy_prev)
                chk("b0_after_grant_and_credit", 64'(gc_prev), 64'd1);
            if (!trn_tsrc_rdy_n)
                chk("owner_flags_while_valid", 64'({tx_driving, tx_req, trn_tsrc_dsc_n}), 64'h7);
            if (held) begin
                chk("beat_held_td", trn_td, held_td);
                chk("beat_held_ctl", 64'({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n}),
                    64'(held_ctl));
            end
            held = 1'b0;
            if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
                chk("sof_position", 64'(trn_tsof_n), 64'(beat_idx != 0));
                chk("eof_position", 64'(trn_teof_n), 64'(beat_idx != 2));
                got[beat_idx] = trn_td;
                if (beat_idx == 2) begin
                    chk("pending_tlps_at_eof", 64'(exp_q.size()), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("beat0", got[0], e.b0);
                        chk("beat1", got[1], e.b1);
                        chk("beat2", got[2], e.b2);
                        chk("trem_n", 64'(trn_trem_n), 64'(e.trem));
                        model_last = ptr_q.pop_front();
                    end
                    last_b0   = got[0];
                    last_b1   = got[1];
                    last_b2   = got[2];
                    last_trem = trn_trem_n;
                    tlp_cnt++;
                    have_eof  = 1'b1;
                    eof_edge  = cyc + 1;
                    beat_idx  = 0;
                end else begin
                    beat_idx++;
                end
            end else if (!trn_tsrc_rdy_n) begin
                held     = 1'b1;
                held_td  = trn_td;
                held_ctl = {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n};
            end
        end
        req_prev   = tx_req;
        srdy_prev  = trn_tsrc_rdy_n;
        gc_prev    = tx_grant & trn_tbuf_av[1];
        prev_ptr   = hw_pointer;
        prev_addr  = host_addr;
        prev_valid = host_addr_valid;
    end

    // Destination-ready driver: 0 = always ready, 1 = two busy cycles then
    // ready, 2 = random, other = left to the main sequence.
    initial begin
        forever begin
            @(posedge trn_clk);
            #2;
            case (rdy_mode)
                0: trn_tdst_rdy_n = 1'b0;
                1: begin
                    trn_tdst_rdy_n = (ph != 2);
                    ph = (ph == 2) ? 0 : ph + 1;
                end
                2: trn_tdst_rdy_n = ($urandom_range(0, 3) == 0);
                default: ;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge trn_clk);
        #1;
    endtask

    task automatic wait_tlps(input int target, input int budget, input string nm);
        int n = 0;
        while (tlp_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        chk(nm, 64'(tlp_cnt >= target), 64'd1);
    endtask

    task automatic settle(input int budget, input string nm);
        int n = 0;
        while ((model_last !== hw_pointer || tx_req) && n < budget) begin
            tick(1);
            n++;
        end
        chk(nm, model_last, hw_pointer);
    endtask

    initial begin
        int c0;
        int n;
        reset            = 1'b1;
        hw_pointer       = 64'h0000_0000_0000_0080;
        host_addr        = 64'h0000_0000_1000_0040;
        host_addr_valid  = 1'b1;
        cfg_completer_id = 16'h0A5C;
        trn_tbuf_av      = 4'hF;
        tx_grant         = 1'b1;
        trn_tdst_rdy_n   = 1'b0;
        tick(3);
        chk("reset_td", trn_td, 64'h0);
        chk("reset_trem", 64'(trn_trem_n), 64'h00);
        chk("reset_framing", 64'({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n}), 64'hF);
        chk("reset_req_drv", 64'({tx_req, tx_driving}), 64'h0);

        // First write with a low address: MWr32 with known beats.
        reset = 1'b0;
        wait_tlps(1, 40, "first_tlp_sent");
        chk("mwr32_b0", last_b0, 64'h4000_0002_0A5C_00FF);
        chk("mwr32_b1", last_b1, 64'h1000_0040_8000_0000);
        chk("mwr32_b2", last_b2, 64'h0000_0000_0000_0000);
        chk("mwr32_trem", 64'(last_trem), 64'h0F);

`ifdef HW_PTR_MWR64_EN
        reset = 1'b1;
        host_addr = 64'h0000_0001_2000_0000;
        tick(2);
        reset = 1'b0;
        c0 = tlp_cnt;
        wait_tlps(c0 + 1, 40, "mwr64_sent");
        chk("mwr64_dw0", 64'(last_b0[63:32]), 64'h6000_0002);
        chk("mwr64_b1", last_b1, 64'h0000_0001_2000_0000);
        chk("mwr64_b2", last_b2, 64'h8000_0000_0000_0000);
        chk("mwr64_trem", 64'(last_trem), 64'h00);
        host_addr = 64'h0000_0000_1000_0040;
`endif

        // Destination stalls two cycles on every beat.
        rdy_mode = 1;
        c0 = tlp_cnt;
        hw_pointer = 64'h1122_3344_5566_7788;
        wait_tlps(c0 + 1, 80, "stalled_tlp_sent");
        rdy_mode = 0;

        // No posted credit: the block must wait with the bus idle.
        trn_tbuf_av = 4'b1101;
        hw_pointer = 64'h0000_0000_0000_0123;
        c0 = tlp_cnt;
        n = 0;
        while (!tx_req && n < 40) begin
            tick(1);
            n++;
        end
        chk("req_without_credit", 64'(tx_req), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("idle_without_credit", 64'({trn_tsrc_rdy_n, tx_driving}), 64'b10);
        end
        trn_tbuf_av = 4'hF;
        tick(1);
        chk("b0_when_credit_returns", 64'({trn_tsrc_rdy_n, trn_tsof_n, tx_driving}), 64'b001);
        wait_tlps(c0 + 1, 20, "credit_tlp_sent");

        // Address not valid: a pointer change must not be reported.
        host_addr_valid = 1'b0;
        hw_pointer = 64'hDEAD_BEEF_0000_0001;
        c0 = tlp_cnt;
        tick(30);
        chk("no_req_while_invalid", 64'({tx_req, trn_tsrc_rdy_n}), 64'b01);
        chk("no_tlp_while_invalid", 64'(tlp_cnt), 64'(c0));
        host_addr_valid = 1'b1;
        wait_tlps(c0 + 1, 40, "tlp_after_valid");

        // Pointer and address move every cycle.
        c0 = tlp_cnt;
        for (int i = 0; i < 200; i++) begin
            hw_pointer = hw_pointer + 64'd1;
            host_addr = {($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'h0,
                         32'($urandom) & 32'hFFFF_FFFC};
            tick(1);
        end
        chk("tlps_while_incrementing", 64'(tlp_cnt - c0 >= 15), 64'd1);
        settle(60, "final_increment_sent");

        // Random traffic with arbitration, credit and ready noise.
        rdy_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) hw_pointer = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 15) == 0)
                host_addr = {($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'h0,
                             32'($urandom) & 32'hFFFF_FFFC};
            host_addr_valid = ($urandom_range(0, 9) != 0);
            tx_grant = ($urandom_range(0, 3) != 0);
            trn_tbuf_av = 4'($urandom);
            tick(1);
        end
        rdy_mode = 0;
        host_addr_valid = 1'b1;
        tx_grant = 1'b1;
        trn_tbuf_av = 4'hF;
        settle(100, "random_final_sent");

        // Reset while beat 1 is on the bus, then expect a resend.
        rdy_mode = 3;
        trn_tdst_rdy_n = 1'b0;
        hw_pointer = 64'h0BAD_F00D_CAFE_0042;
        c0 = tlp_cnt;
        n = 0;
        while (!(!trn_tsrc_rdy_n && !trn_tsof_n) && n < 60) begin
            tick(1);
            n++;
        end
        chk("b0_before_reset", 64'({trn_tsrc_rdy_n, trn_tsof_n}), 64'b00);
        tick(1);
        trn_tdst_rdy_n = 1'b1;
        reset = 1'b1;
        chk("b1_before_reset", 64'({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}), 64'b011);
        tick(1);
        chk("midtlp_reset_framing", 64'({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}), 64'b111);
        chk("midtlp_reset_owner", 64'({tx_req, tx_driving}), 64'b00);
        chk("midtlp_reset_td", trn_td, 64'h0);
        reset = 1'b0;
        trn_tdst_rdy_n = 1'b0;
        wait_tlps(c0 + 1, 60, "resend_after_reset");
        chk("resend_value", model_last, hw_pointer);
        tick(3);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
